// File: rtl/lc4_divider_seq.sv
// Multi-cycle unsigned 16-bit restoring divider for LC4 DIV/MOD.
// Performs ITERS_PER_CYCLE iterations per enabled edge; divide-by-zero yields 0/0.
module lc4_divider_seq #(
   parameter int unsigned ITERS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gwe,
   input  logic        i_start,
   input  logic [15:0] i_dividend,
   input  logic [15:0] i_divisor,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_quotient,
   output logic [15:0] o_remainder
);

   localparam int unsigned W   = 16;
   localparam int unsigned CW  = 5;
   localparam int unsigned LAT = W / ITERS_PER_CYCLE;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   dvd_q, dvd_d;
   logic [W-1:0]   dvs_q, dvs_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W:0]     rem_q, rem_d;
   logic           zero_q, zero_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           busy_d, done_d;
   logic [W-1:0]   q_out_d, r_out_d;

   // Next-state, datapath iterations and output updates
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      busy_d  = o_busy;
      done_d  = o_done;
      q_out_d = o_quotient;
      r_out_d = o_remainder;

      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (i_start) begin
               dvd_d   = i_dividend;
               dvs_d   = i_divisor;
               zero_d  = (i_divisor == '0);
               rem_d   = '0;
               quo_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            for (int unsigned i = 0; i < ITERS_PER_CYCLE; i++) begin
               rem_d = {rem_d[W-1:0], dvd_d[W-1]};
               dvd_d = {dvd_d[W-2:0], 1'b0};
               if (rem_d >= {1'b0, dvs_q}) begin
                  rem_d = rem_d - {1'b0, dvs_q};
                  quo_d = {quo_d[W-2:0], 1'b1};
               end else begin
                  quo_d = {quo_d[W-2:0], 1'b0};
               end
            end
            cnt_d = cnt_q + CW'(1);
            // Last iteration batch: publish results and return to idle
            if (cnt_d == CW'(LAT)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               q_out_d = zero_q ? '0 : quo_d;
               r_out_d = zero_q ? '0 : rem_d[W-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; gwe gates every update except reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         zero_q      <= 1'b0;
         cnt_q       <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
      end else if (gwe) begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         zero_q      <= zero_d;
         cnt_q       <= cnt_d;
         o_busy      <= busy_d;
         o_done      <= done_d;
         o_quotient  <= q_out_d;
         o_remainder <= r_out_d;
      end
   end

endmodule

// File: tb/tb_lc4_divider_seq.sv
// Bench for lc4_divider_seq: directed handshake/stall/reset cases plus random
// operands on three instances (1, 4, 16 iterations per cycle) against a / and % model.
module tb_lc4_divider_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        gwe;
   logic        start [3];
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy [3];
   logic        done [3];
   logic [15:0] quo [3];
   logic [15:0] rem [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lc4_divider_seq #(.ITERS_PER_CYCLE(1)) u_div1 (
      .clk(clk), .rst(rst), .gwe(gwe), .i_start(start[0]),
      .i_dividend(dividend), .i_divisor(divisor),
      .o_busy(busy[0]), .o_done(done[0]), .o_quotient(quo[0]), .o_remainder(rem[0]));

   lc4_divider_seq #(.ITERS_PER_CYCLE(4)) u_div4 (
      .clk(clk), .rst(rst), .gwe(gwe), .i_start(start[1]),
      .i_dividend(dividend), .i_divisor(divisor),
      .o_busy(busy[1]), .o_done(done[1]), .o_quotient(quo[1]), .o_remainder(rem[1]));

   lc4_divider_seq #(.ITERS_PER_CYCLE(16)) u_div16 (
      .clk(clk), .rst(rst), .gwe(gwe), .i_start(start[2]),
      .i_dividend(dividend), .i_divisor(divisor),
      .o_busy(busy[2]), .o_done(done[2]), .o_quotient(quo[2]), .o_remainder(rem[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_q(input logic [15:0] a, input logic [15:0] b);
      return (b == 16'd0) ? 16'd0 : 16'(a / b);
   endfunction

   function automatic logic [15:0] model_r(input logic [15:0] a, input logic [15:0] b);
      return (b == 16'd0) ? 16'd0 : 16'(a % b);
   endfunction

   // Step negedges until done rises (bounded); counts cycles and busy-high cycles
   task automatic wait_done(input int k, output int n, output int nb);
      n  = 0;
      nb = 0;
      while (done[k] !== 1'b1 && n < 200) begin
         if (busy[k] === 1'b1) nb++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         input int lat, input logic [15:0] eq, input logic [15:0] er);
      int n, nb;
      @(negedge clk);
      start[k] = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start[k] = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
      wait_done(k, n, nb);
      check("latency", 32'(n), 32'(lat));
      check("busy_cycles", 32'(nb), 32'(lat));
      check("quotient", 32'(quo[k]), 32'(eq));
      check("remainder", 32'(rem[k]), 32'(er));
      check("busy_in_done", 32'(busy[k]), 32'd0);
   endtask

   initial begin
      int n, nb, cnt;
      logic [15:0] a, b;
      int lats [3];
      lats[0] = 16; lats[1] = 4; lats[2] = 1;

      rst = 1'b1; gwe = 1'b1; dividend = '0; divisor = '0;
      for (int k = 0; k < 3; k++) start[k] = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("reset_busy", 32'(busy[k]), 32'd0);
         check("reset_done", 32'(done[k]), 32'd0);
         check("reset_q", 32'(quo[k]), 32'd0);
         check("reset_r", 32'(rem[k]), 32'd0);
      end
      rst = 1'b0;

      // Directed cases on the one-iteration-per-cycle instance
      run_op(0, 16'h1234, 16'h0011, 16, 16'h0112, 16'h0002);
      run_op(0, 16'hFFFF, 16'h0001, 16, 16'hFFFF, 16'h0000);
      run_op(0, 16'hFFFF, 16'hFFFF, 16, 16'h0001, 16'h0000);
      run_op(0, 16'h0005, 16'h0009, 16, 16'h0000, 16'h0005);
      run_op(0, 16'h0007, 16'h0000, 16, 16'h0000, 16'h0000);

      // Start during busy is ignored; held start in the done cycle is accepted
      @(negedge clk);
      start[0] = 1'b1; dividend = 16'h0064; divisor = 16'h0007;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      start[0] = 1'b1; dividend = 16'h0001; divisor = 16'h0001;
      wait_done(0, n, nb);
      check("hs_latency", 32'(n), 32'd14);
      check("hs_q", 32'(quo[0]), 32'h000E);
      check("hs_r", 32'(rem[0]), 32'h0002);
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, n, nb);
      check("b2b_latency", 32'(n + 1), 32'd17);
      check("b2b_q", 32'(quo[0]), 32'h0001);
      check("b2b_r", 32'(rem[0]), 32'h0000);

      // gwe stall of five edges mid-operation, then done held across gwe=0
      @(negedge clk);
      start[0] = 1'b1; dividend = 16'hBEEF; divisor = 16'h0123;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      gwe = 1'b0;
      repeat (5) @(negedge clk);
      check("stall_busy", 32'(busy[0]), 32'd1);
      gwe = 1'b1;
      wait_done(0, n, nb);
      check("stall_latency", 32'(n + 8), 32'd21);
      check("stall_q", 32'(quo[0]), 32'(model_q(16'hBEEF, 16'h0123)));
      check("stall_r", 32'(rem[0]), 32'(model_r(16'hBEEF, 16'h0123)));
      gwe = 1'b0;
      repeat (2) @(negedge clk);
      check("done_hold", 32'(done[0]), 32'd1);
      gwe = 1'b1;
      @(negedge clk);
      check("done_drop", 32'(done[0]), 32'd0);

      // Reset mid-operation abandons the division
      @(negedge clk);
      start[0] = 1'b1; dividend = 16'h1234; divisor = 16'h0011;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_done", 32'(done[0]), 32'd0);
      check("midrst_q", 32'(quo[0]), 32'd0);
      check("midrst_r", 32'(rem[0]), 32'd0);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done[0] === 1'b1) cnt++;
      end
      check("midrst_no_done", 32'(cnt), 32'd0);

      // Random operands, about 10% divide-by-zero, per instance
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(9) == 0) ? 16'd0 : 16'($urandom);
            run_op(k, a, b, lats[k], model_q(a, b), model_r(a, b));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
